// File: rtl/ins_encoder.sv
// ins_encoder: packs decoded RV32I instruction fields back into 32-bit
// instruction words, buffers them in a small FIFO, and presents each word
// with a sequential byte address for the instruction-memory writer.
module ins_encoder #(
    parameter int unsigned    DEPTH = 4,
    parameter int unsigned    AW    = 32,
    parameter logic [AW-1:0]  BASE  = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               opcode,
    input  logic [2:0]               func3,
    input  logic                     func7,
    input  logic [4:0]               rd,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    input  logic [11:0]              imm12,
    input  logic [19:0]              imm20,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_ins,
    output logic [AW-1:0]            out_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        T_R, T_I, T_S, T_B, T_U, T_J, T_X
    } ins_type_t;

    ins_type_t          ins_type;
    logic [31:0]        word;
    logic               known;
    logic               consume;
    logic               push;
    logic               pop;

    logic [31:0]        mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      occ;
    logic [AW-1:0]      addr;
    logic               err_q;

    // Classify the instruction format from the opcode.
    always_comb begin
        ins_type = T_X;
        case (opcode)
            7'b0110011:                         ins_type = T_R;
            7'b0010011, 7'b0000011, 7'b1100111: ins_type = T_I;
            7'b0100011:                         ins_type = T_S;
            7'b1100011:                         ins_type = T_B;
            7'b0110111, 7'b0010111:             ins_type = T_U;
            7'b1101111:                         ins_type = T_J;
            default:                            ins_type = T_X;
        endcase
    end

    // Scatter the decode-layout fields into their instruction-word positions.
    always_comb begin
        word = '0;
        case (ins_type)
            T_R: word = {1'b0, func7, 5'b0, rs2, rs1, func3, rd, opcode};
            T_I: word = {imm12, rs1, func3, rd, opcode};
            T_S: word = {imm12[11:5], rs2, rs1, func3, imm12[4:0], opcode};
            T_B: word = {imm12[11], imm12[9:4], rs2, rs1, func3,
                         imm12[3:0], imm12[10], opcode};
            T_U: word = {imm20, rd, opcode};
            T_J: word = {imm20[19], imm20[9:0], imm20[10], imm20[18:11],
                         rd, opcode};
            default: word = '0;
        endcase
    end

    assign known     = (ins_type != T_X);
    assign in_ready  = (occ != CW'(DEPTH));
    assign out_valid = (occ != '0);
    assign consume   = in_valid && in_ready;
    assign push      = consume && known;
    assign pop       = out_valid && out_ready;

    assign out_ins   = out_valid ? mem[rd_ptr] : '0;
    assign out_addr  = addr;
    assign count     = occ;
    assign err       = err_q;

    // FIFO storage; contents are only visible through out_valid-gated reads.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= word;
    end

    // Pointers, occupancy, address counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            addr   <= BASE;
            err_q  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                addr   <= addr + AW'(4);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
            if (consume && !known)
                err_q <= 1'b1;
        end
    end

endmodule
